// File: rtl/int_ack_ctrl.sv
// rtl/int_ack_ctrl.sv - acknowledge-side controller of the PIC (priority, ISR, INTA vector, EOI)
//
// Ports:
//   clock                      system clock
//   reset                      asynchronous active-low reset
//   interrupt_request_register IRR from the request register block
//   interrupt_mask             1 = line masked
//   vector_base                T7..T3 of the vector byte
//   auto_eoi_config            1 = clear the acknowledged ISR bit at the end of the second INTA
//   eoi                        one-cycle non-specific EOI strobe
//   inta_n                     INTA pin, already synchronized to clock
//   int_out                    INT to CPU
//   freeze                     holds the IRR stable during the acknowledge sequence
//   clear_interrupt_request    one-cycle one-hot clear pulse to the IRR
//   in_service_register        current ISR
//   data_out                   vector byte
//   data_out_enable            drives data_out onto the bus
module int_ack_ctrl #(
  parameter int IRQ_WIDTH    = 8,
  parameter int SPURIOUS_IRQ = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi_config,
  input  logic       eoi,
  input  logic       inta_n,
  output logic       int_out,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] data_out,
  output logic       data_out_enable
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2, DONE} state_t;

  state_t     state;
  logic       inta_prev;
  logic [7:0] vector;
  logic [2:0] ack_idx;
  logic       ack_spurious;

  logic       fall;
  logic       rise;
  logic [3:0] isr_top;
  logic [7:0] eligible;
  logic       win_valid;
  logic [2:0] win;
  logic [7:0] win_onehot;
  logic [7:0] ack_onehot;
  logic [7:0] eoi_clr;
  logic [7:0] isr_after_eoi;

  assign fall = inta_prev & ~inta_n;
  assign rise = ~inta_prev & inta_n;

  // Fully nested priority: IR0 highest, a line may only interrupt lines of
  // lower priority than the highest one currently in service.
  always_comb begin
    isr_top = 4'd8;
    for (int i = IRQ_WIDTH - 1; i >= 0; i--) begin
      if (in_service_register[i]) isr_top = 4'(i);
    end
    eligible = '0;
    for (int i = 0; i < IRQ_WIDTH; i++) begin
      eligible[i] = interrupt_request_register[i] & ~interrupt_mask[i] & (4'(i) < isr_top);
    end
    win_valid = |eligible;
    win = 3'd0;
    for (int i = IRQ_WIDTH - 1; i >= 0; i--) begin
      if (eligible[i]) win = 3'(i);
    end
  end

  assign win_onehot    = 8'b1 << win;
  assign ack_onehot    = 8'b1 << ack_idx;
  // EOI always works on the pre-update ISR so a bit set this cycle survives.
  assign eoi_clr       = (eoi && !isr_top[3]) ? (8'b1 << isr_top[2:0]) : 8'b0;
  assign isr_after_eoi = in_service_register & ~eoi_clr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      inta_prev               <= 1'b1;
      vector                  <= 8'h00;
      ack_idx                 <= 3'd0;
      ack_spurious            <= 1'b0;
      int_out                 <= 1'b0;
      freeze                  <= 1'b0;
      clear_interrupt_request <= 8'h00;
      in_service_register     <= 8'h00;
      data_out                <= 8'h00;
      data_out_enable         <= 1'b0;
    end else begin
      inta_prev               <= inta_n;
      clear_interrupt_request <= 8'h00;
      in_service_register     <= isr_after_eoi;
      int_out                 <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state  <= ACK1;
            freeze <= 1'b1;
            if (win_valid) begin
              in_service_register     <= isr_after_eoi | win_onehot;
              clear_interrupt_request <= win_onehot;
              vector                  <= {vector_base, win};
              ack_idx                 <= win;
              ack_spurious            <= 1'b0;
            end else begin
              vector       <= {vector_base, 3'(SPURIOUS_IRQ)};
              ack_idx      <= 3'(SPURIOUS_IRQ);
              ack_spurious <= 1'b1;
            end
          end else begin
            int_out <= win_valid;
          end
        end
        ACK1: begin
          if (rise) state <= ACK2;
        end
        ACK2: begin
          if (fall) begin
            state           <= DONE;
            data_out        <= vector;
            data_out_enable <= 1'b1;
          end
        end
        DONE: begin
          if (rise) begin
            state           <= IDLE;
            data_out        <= 8'h00;
            data_out_enable <= 1'b0;
            freeze          <= 1'b0;
            if (auto_eoi_config && !ack_spurious) begin
              in_service_register <= isr_after_eoi & ~ack_onehot;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ack_ctrl.sv
// tb/tb_int_ack_ctrl.sv - directed self-checking bench for int_ack_ctrl
module tb_int_ack_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] irr;
  logic [7:0] mask;
  logic [4:0] vector_base;
  logic       auto_eoi_config;
  logic       eoi;
  logic       inta_n;
  logic       int_out;
  logic       freeze;
  logic [7:0] clear_irq;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_out_enable;

  int checks   = 0;
  int failures = 0;

  int_ack_ctrl dut (
    .clock                      (clock),
    .reset                      (reset),
    .interrupt_request_register (irr),
    .interrupt_mask             (mask),
    .vector_base                (vector_base),
    .auto_eoi_config            (auto_eoi_config),
    .eoi                        (eoi),
    .inta_n                     (inta_n),
    .int_out                    (int_out),
    .freeze                     (freeze),
    .clear_interrupt_request    (clear_irq),
    .in_service_register        (isr),
    .data_out                   (data_out),
    .data_out_enable            (data_out_enable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic inta_fall();
    inta_n = 1'b0;
    tick();
  endtask

  task automatic inta_rise();
    inta_n = 1'b1;
    tick();
  endtask

  initial begin
    reset           = 1'b0;
    irr             = 8'h00;
    mask            = 8'h00;
    vector_base     = 5'h10;
    auto_eoi_config = 1'b0;
    eoi             = 1'b0;
    inta_n          = 1'b1;
    tick();
    tick();
    check("rst_int",   int_out, 0);
    check("rst_frz",   freeze, 0);
    check("rst_clr",   clear_irq, 8'h00);
    check("rst_isr",   isr, 8'h00);
    check("rst_dout",  data_out, 8'h00);
    check("rst_doe",   data_out_enable, 0);
    reset = 1'b1;
    tick();

    // 1: single request on IR2
    irr = 8'h04;
    check("t1_int_pre", int_out, 0);
    tick();
    check("t1_int", int_out, 1);
    inta_fall();
    check("t1_clr", clear_irq, 8'h04);
    check("t1_isr", isr, 8'h04);
    check("t1_frz", freeze, 1);
    check("t1_int_drop", int_out, 0);
    irr = 8'h00;
    tick();
    check("t1_clr_once", clear_irq, 8'h00);
    inta_rise();
    check("t1_frz_ack2", freeze, 1);
    check("t1_doe_ack2", data_out_enable, 0);
    inta_fall();
    check("t1_doe", data_out_enable, 1);
    check("t1_vec", data_out, 8'h82);
    tick();
    check("t1_vec_hold", data_out, 8'h82);
    inta_rise();
    check("t1_doe_end", data_out_enable, 0);
    check("t1_frz_end", freeze, 0);
    check("t1_isr_keep", isr, 8'h04);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t1_isr_eoi", isr, 8'h00);

    // 2: nested priority, IR1 blocks IR4 until EOI
    irr = 8'h12;
    tick();
    check("t2_int", int_out, 1);
    inta_fall();
    check("t2_clr", clear_irq, 8'h02);
    check("t2_isr", isr, 8'h02);
    irr = 8'h10;
    inta_rise();
    inta_fall();
    check("t2_vec", data_out, 8'h81);
    inta_rise();
    tick();
    check("t2_int_blocked", int_out, 0);
    check("t2_isr_keep", isr, 8'h02);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t2_isr_eoi", isr, 8'h00);
    tick();
    check("t2_int_ir4", int_out, 1);
    inta_fall();
    check("t2_clr4", clear_irq, 8'h10);
    check("t2_isr4", isr, 8'h10);
    irr = 8'h00;
    inta_rise();
    inta_fall();
    check("t2_vec4", data_out, 8'h84);
    inta_rise();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t2_isr4_eoi", isr, 8'h00);

    // 3: automatic EOI on IR7
    auto_eoi_config = 1'b1;
    irr = 8'h80;
    tick();
    check("t3_int", int_out, 1);
    inta_fall();
    check("t3_isr_set", isr, 8'h80);
    irr = 8'h00;
    inta_rise();
    inta_fall();
    check("t3_vec", data_out, 8'h87);
    check("t3_isr_mid", isr, 8'h80);
    inta_rise();
    check("t3_isr_aeoi", isr, 8'h00);
    check("t3_doe_end", data_out_enable, 0);
    auto_eoi_config = 1'b0;

    // 4: spurious acknowledge
    vector_base = 5'h03;
    tick();
    check("t4_int", int_out, 0);
    inta_fall();
    check("t4_clr", clear_irq, 8'h00);
    check("t4_isr", isr, 8'h00);
    check("t4_frz", freeze, 1);
    inta_rise();
    inta_fall();
    check("t4_vec", data_out, 8'h1F);
    inta_rise();
    check("t4_isr_end", isr, 8'h00);
    vector_base = 5'h10;

    // 5: masking
    mask = 8'hFF;
    irr  = 8'h01;
    tick();
    tick();
    check("t5_masked", int_out, 0);
    mask = 8'hFE;
    tick();
    check("t5_unmasked", int_out, 1);

    // 6: reset in the middle of the sequence
    inta_fall();
    check("t6_clr", clear_irq, 8'h01);
    check("t6_isr", isr, 8'h01);
    inta_rise();
    inta_fall();
    check("t6_doe_pre", data_out_enable, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_int",  int_out, 0);
    check("t6_rst_frz",  freeze, 0);
    check("t6_rst_clr",  clear_irq, 8'h00);
    check("t6_rst_isr",  isr, 8'h00);
    check("t6_rst_dout", data_out, 8'h00);
    check("t6_rst_doe",  data_out_enable, 0);
    inta_n = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("t6_int", int_out, 1);
    inta_fall();
    check("t6_clr2", clear_irq, 8'h01);
    irr = 8'h00;
    inta_rise();
    inta_fall();
    check("t6_vec", data_out, 8'h80);
    inta_rise();
    check("t6_isr_end", isr, 8'h01);
    check("t6_frz_end", freeze, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
